// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and port identifiers.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_access_arbiter_if.sv
// Requester and memory-side signal bundle of the data-memory arbiter.
// The slave modport is the arbiter view; master is the requesters/memory view.
interface dmem_access_arbiter_if #(
  parameter int DW = 32
);
  logic          p0_req_i;
  logic          p0_we_i;
  logic [DW-1:0] p0_addr_i;
  logic [DW-1:0] p0_wdata_i;
  logic          p0_ready_o;
  logic          p0_done_o;
  logic [DW-1:0] p0_rdata_o;
  logic          p0_err_o;

  logic          p1_req_i;
  logic          p1_we_i;
  logic [DW-1:0] p1_addr_i;
  logic [DW-1:0] p1_wdata_i;
  logic          p1_ready_o;
  logic          p1_done_o;
  logic [DW-1:0] p1_rdata_o;
  logic          p1_err_o;

  logic [DW-1:0] mem_address_o;
  logic [DW-1:0] mem_write_data_o;
  logic          mem_write_o;
  logic          mem_read_o;
  logic [DW-1:0] mem_data_i;

  modport slave (
    input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
    output p0_ready_o, p0_done_o, p0_rdata_o, p0_err_o,
    input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
    output p1_ready_o, p1_done_o, p1_rdata_o, p1_err_o,
    output mem_address_o, mem_write_data_o, mem_write_o, mem_read_o,
    input  mem_data_i
  );

  modport master (
    output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
    input  p0_ready_o, p0_done_o, p0_rdata_o, p0_err_o,
    output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
    input  p1_ready_o, p1_done_o, p1_rdata_o, p1_err_o,
    input  mem_address_o, mem_write_data_o, mem_write_o, mem_read_o,
    output mem_data_i
  );

endinterface

// File: rtl/dmem_rr_arbiter.sv
// Two-way round-robin grant; the pointer names the port that wins a tie and
// flips to the other port whenever a grant is issued.
module dmem_rr_arbiter
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  // Grant selection and pointer update
  always_comb begin
    gnt0_o   = 1'b0;
    gnt1_o   = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (en_i) begin
      if (req0_i && (!req1_i || (rr_ptr_q == PORT_CPU))) begin
        gnt0_o   = 1'b1;
        rr_ptr_d = PORT_DBG;
      end else if (req1_i) begin
        gnt1_o   = 1'b1;
        rr_ptr_d = PORT_CPU;
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= PORT_CPU;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares one single-port data memory between a CPU port and a debug/DMA port.
// Optional address checking is enabled by defining DMEM_ARB_ADDR_CHECK_EN.
module dmem_access_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 10
) (
  input logic                 clk,
  input logic                 reset,
  dmem_access_arbiter_if.slave bus
);

`ifdef DMEM_ARB_ADDR_CHECK_EN
  localparam logic ADDR_CHECK_EN = 1'b1;
`else
  localparam logic ADDR_CHECK_EN = 1'b0;
`endif

  arb_state_e            state_q, state_d;
  logic                  cmd_port_q, cmd_we_q, cmd_bad_q;
  logic [DATA_WIDTH-1:0] cmd_addr_q, cmd_wdata_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
  logic                  err0_q, err1_q;

  logic                  gnt0_s, gnt1_s, accept_s, live_s;
  logic                  sel_we_s, sel_bad_s;
  logic [DATA_WIDTH-1:0] sel_addr_s, sel_wdata_s, cap_data_s;

  // Gating with reset keeps ready low while the block is held in reset.
  dmem_rr_arbiter u_rr (
    .clk    (clk),
    .reset  (reset),
    .en_i   ((state_q == IDLE) && reset),
    .req0_i (bus.p0_req_i),
    .req1_i (bus.p1_req_i),
    .gnt0_o (gnt0_s),
    .gnt1_o (gnt1_s)
  );

  assign accept_s       = gnt0_s | gnt1_s;
  assign bus.p0_ready_o = gnt0_s;
  assign bus.p1_ready_o = gnt1_s;

  assign sel_we_s    = gnt1_s ? bus.p1_we_i    : bus.p0_we_i;
  assign sel_addr_s  = gnt1_s ? bus.p1_addr_i  : bus.p0_addr_i;
  assign sel_wdata_s = gnt1_s ? bus.p1_wdata_i : bus.p0_wdata_i;
  assign sel_bad_s   = ADDR_CHECK_EN &&
                       ((sel_addr_s[DATA_WIDTH-1:MEM_ADDR_BITS] != '0) || (sel_addr_s[1:0] != 2'b00));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latch, loaded on the accept edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_port_q  <= PORT_CPU;
      cmd_we_q    <= 1'b0;
      cmd_bad_q   <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else if (accept_s) begin
      cmd_port_q  <= gnt1_s ? PORT_DBG : PORT_CPU;
      cmd_we_q    <= sel_we_s;
      cmd_bad_q   <= sel_bad_s;
      cmd_addr_q  <= sel_addr_s;
      cmd_wdata_q <= sel_wdata_s;
    end else begin
      cmd_port_q  <= cmd_port_q;
      cmd_we_q    <= cmd_we_q;
      cmd_bad_q   <= cmd_bad_q;
      cmd_addr_q  <= cmd_addr_q;
      cmd_wdata_q <= cmd_wdata_q;
    end
  end

  // A flagged command turns ACCESS into a dead cycle with the memory bus idle.
  assign live_s               = (state_q == ACCESS) && !cmd_bad_q;
  assign bus.mem_write_o      = live_s && cmd_we_q;
  assign bus.mem_read_o       = live_s && !cmd_we_q;
  assign bus.mem_address_o    = live_s ? cmd_addr_q : '0;
  assign bus.mem_write_data_o = (live_s && cmd_we_q) ? cmd_wdata_q : '0;
  assign cap_data_s           = (cmd_bad_q || cmd_we_q) ? '0 : bus.mem_data_i;

  // Per-port result registers; only the granted port is updated
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else if (state_q == ACCESS) begin
      if (cmd_port_q == PORT_DBG) begin
        rdata1_q <= cap_data_s;
        err1_q   <= cmd_bad_q;
      end else begin
        rdata0_q <= cap_data_s;
        err0_q   <= cmd_bad_q;
      end
    end else begin
      rdata0_q <= rdata0_q;
      rdata1_q <= rdata1_q;
      err0_q   <= err0_q;
      err1_q   <= err1_q;
    end
  end

  assign bus.p0_done_o  = (state_q == DONE) && (cmd_port_q == PORT_CPU);
  assign bus.p1_done_o  = (state_q == DONE) && (cmd_port_q == PORT_DBG);
  assign bus.p0_rdata_o = rdata0_q;
  assign bus.p1_rdata_o = rdata1_q;
  assign bus.p0_err_o   = err0_q;
  assign bus.p1_err_o   = err1_q;

endmodule
